// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between two requesters.
// Optional grant counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_out_data
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  grant0_count,
  output logic [CNT_W-1:0]  grant1_count
`endif
);

  logic              r_rr_ptr;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic [DATA_W-1:0] r_rsp0_rdata;
  logic [DATA_W-1:0] r_rsp1_rdata;
  logic              w_gnt_vld;
  logic              w_gnt_port;

  // Reset masks the grant so no handshake or write can slip through during reset.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_port = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = r_rr_ptr;
      end else if (req0_valid) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = 1'b0;
      end else if (req1_valid) begin
        w_gnt_vld  = 1'b1;
        w_gnt_port = 1'b1;
      end
    end
  end

  assign req0_ready       = w_gnt_vld && !w_gnt_port;
  assign req1_ready       = w_gnt_vld && w_gnt_port;
  assign mem_address      = req1_ready ? req1_addr  : req0_addr;
  assign mem_write_data   = req1_ready ? req1_wdata : req0_wdata;
  assign mem_write_enable = req1_ready ? req1_we : (req0_ready && req0_we);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr     <= 1'b0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
    end else begin
      if (w_gnt_vld) begin
        r_rr_ptr <= ~w_gnt_port;
      end
      r_rsp0_valid <= req0_ready && !req0_we;
      r_rsp1_valid <= req1_ready && !req1_we;
      if (req0_ready && !req0_we) begin
        r_rsp0_rdata <= mem_out_data;
      end
      if (req1_ready && !req1_we) begin
        r_rsp1_rdata <= mem_out_data;
      end
    end
  end

  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp1_rdata = r_rsp1_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_ready && (r_cnt0 != {CNT_W{1'b1}})) begin
        r_cnt0 <= r_cnt0 + 1'b1;
      end
      if (req1_ready && (r_cnt1 != {CNT_W{1'b1}})) begin
        r_cnt1 <= r_cnt1 + 1'b1;
      end
    end
  end

  assign grant0_count = r_cnt0;
  assign grant1_count = r_cnt1;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table followed by randomized traffic
// checked against a queue-free behavioural model of the round-robin arbiter.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0_valid, req0_ready, req0_we, rsp0_valid;
  logic              req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [ADDR_W-1:0] req0_addr, req1_addr, mem_address;
  logic [DATA_W-1:0] req0_wdata, req1_wdata, rsp0_rdata, rsp1_rdata;
  logic [DATA_W-1:0] mem_write_data, mem_out_data;
  logic              mem_write_enable;
`ifdef DMEM_ARB_STATS_EN
  logic [CNT_W-1:0]  grant0_count, grant1_count;
`endif

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_out_data(mem_out_data)
`ifdef DMEM_ARB_STATS_EN
    , .grant0_count(grant0_count), .grant1_count(grant1_count)
`endif
  );

  always #5 clk = ~clk;

  // Small data memory with combinational read and posedge write.
  logic [DATA_W-1:0] tb_mem [8];
  logic              mem_clr;
  assign mem_out_data = tb_mem[mem_address[2:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) tb_mem[i] <= '0;
    end else if (mem_write_enable) begin
      tb_mem[mem_address[2:0]] <= mem_write_data;
    end
  end

  typedef struct {
    logic        rst;
    logic        v0, we0;
    logic [31:0] a0, d0;
    logic        v1, we1;
    logic [31:0] a1, d1;
    logic        rdy0, rdy1, mwe;
    logic        r0v;
    logic [31:0] r0d;
    logic        r1v;
    logic [31:0] r1d;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic we0, input int a0, input int d0,
                     input logic v1, input logic we1, input int a1, input int d1,
                     input logic rdy0, input logic rdy1, input logic mwe,
                     input logic r0v, input int r0d, input logic r1v, input int r1d);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.mwe = mwe;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic v0, input logic we0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic v1, input logic we1,
                       input logic [31:0] a1, input logic [31:0] d1);
    reset = rst;
    req0_valid = v0; req0_we = we0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_we = we1; req1_addr = a1; req1_wdata = d1;
  endtask

  // Reference model state
  logic              m_ptr;
  logic [DATA_W-1:0] m_mem [8];
  logic              e_r0v, e_r1v;
  logic [DATA_W-1:0] e_r0d, e_r1d;
  int unsigned       e_c0, e_c1;

  initial begin
    mem_clr = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 mem_clr = 1'b0;

    //   rst v0 we0 a0 d0  v1 we1 a1 d1   rdy0 rdy1 mwe  r0v r0d r1v r1d
    add(1, 1, 1, 0, 99, 1, 1, 1, 98,  0, 0, 0,  0, 0,  0, 0);
    add(0, 1, 1, 0, 10, 0, 0, 0, 0,   1, 0, 1,  0, 0,  0, 0);
    add(0, 1, 0, 0, 0,  0, 0, 0, 0,   1, 0, 0,  1, 10, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 10, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 1, 20,  0, 1, 1,  0, 10, 0, 0);
    add(1, 1, 0, 0, 0,  1, 0, 1, 0,   0, 0, 0,  0, 0,  0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 1, 0,   1, 0, 0,  1, 10, 0, 0);
    add(0, 1, 0, 0, 0,  1, 0, 1, 0,   0, 1, 0,  0, 10, 1, 20);
    add(0, 1, 0, 0, 0,  1, 0, 1, 0,   1, 0, 0,  1, 10, 0, 20);
    add(0, 1, 0, 0, 0,  1, 0, 1, 0,   0, 1, 0,  0, 10, 1, 20);
    add(1, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0);
    add(0, 1, 1, 2, 30, 1, 1, 2, 40,  1, 0, 1,  0, 0,  0, 0);
    add(0, 1, 1, 2, 30, 1, 1, 2, 40,  0, 1, 1,  0, 0,  0, 0);
    add(0, 1, 0, 2, 0,  0, 0, 0, 0,   1, 0, 0,  1, 40, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0,   0, 1, 0,  0, 40, 1, 20);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 40, 0, 20);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 40, 0, 20);
    add(0, 0, 0, 0, 0,  0, 0, 0, 0,   0, 0, 0,  0, 40, 0, 20);
    add(0, 1, 0, 2, 0,  1, 0, 1, 0,   1, 0, 0,  1, 40, 0, 20);
    add(0, 1, 1, 3, 55, 0, 0, 0, 0,   1, 0, 1,  0, 40, 0, 20);
    add(0, 1, 0, 3, 0,  0, 0, 0, 0,   1, 0, 0,  1, 55, 0, 20);
    add(1, 1, 0, 3, 0,  0, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0,
            vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1);
      #1;
      chk($sformatf("vec%0d ready0", i), 64'(req0_ready), 64'(vecs[i].rdy0));
      chk($sformatf("vec%0d ready1", i), 64'(req1_ready), 64'(vecs[i].rdy1));
      chk($sformatf("vec%0d mem_we", i), 64'(mem_write_enable), 64'(vecs[i].mwe));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d rsp0_valid", i), 64'(rsp0_valid), 64'(vecs[i].r0v));
      chk($sformatf("vec%0d rsp0_rdata", i), 64'(rsp0_rdata), 64'(vecs[i].r0d));
      chk($sformatf("vec%0d rsp1_valid", i), 64'(rsp1_valid), 64'(vecs[i].r1v));
      chk($sformatf("vec%0d rsp1_rdata", i), 64'(rsp1_rdata), 64'(vecs[i].r1d));
    end

    // Randomized traffic; the last table vector left the DUT in reset.
    m_ptr = 1'b0;
    e_r0v = 1'b0; e_r1v = 1'b0; e_r0d = '0; e_r1d = '0;
    e_c0 = 0; e_c1 = 0;
    for (int i = 0; i < 8; i++) m_mem[i] = tb_mem[i];

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        gv, gp, rd0, rd1, rst_now;
      logic [31:0] ga, gd;
      logic        gwe;
      @(negedge clk);
      rst_now = ($urandom_range(0, 39) == 0);
      drive(rst_now, 1'($urandom), 1'($urandom), 32'($urandom_range(0, 7)), $urandom,
            1'($urandom), 1'($urandom), 32'($urandom_range(0, 7)), $urandom);
      gv = !rst_now && (req0_valid || req1_valid);
      gp = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
      ga  = gp ? req1_addr : req0_addr;
      gd  = gp ? req1_wdata : req0_wdata;
      gwe = gp ? req1_we : req0_we;
      #1;
      chk("rnd ready0", 64'(req0_ready), 64'(gv && !gp));
      chk("rnd ready1", 64'(req1_ready), 64'(gv && gp));
      chk("rnd mem_we", 64'(mem_write_enable), 64'(gv && gwe));
      if (gv) begin
        chk("rnd mem_address", 64'(mem_address), 64'(ga));
        if (gwe) chk("rnd mem_wdata", 64'(mem_write_data), 64'(gd));
      end
      @(posedge clk);
      #1;
      if (rst_now) begin
        m_ptr = 1'b0;
        e_r0v = 1'b0; e_r1v = 1'b0; e_r0d = '0; e_r1d = '0;
        e_c0 = 0; e_c1 = 0;
      end else begin
        rd0 = gv && !gp && !gwe;
        rd1 = gv && gp && !gwe;
        e_r0v = rd0;
        e_r1v = rd1;
        if (rd0) e_r0d = m_mem[ga[2:0]];
        if (rd1) e_r1d = m_mem[ga[2:0]];
        if (gv && gwe) m_mem[ga[2:0]] = gd;
        if (gv) m_ptr = !gp;
        if (gv && !gp && e_c0 < (2**CNT_W - 1)) e_c0++;
        if (gv && gp && e_c1 < (2**CNT_W - 1)) e_c1++;
      end
      chk("rnd rsp0_valid", 64'(rsp0_valid), 64'(e_r0v));
      chk("rnd rsp0_rdata", 64'(rsp0_rdata), 64'(e_r0d));
      chk("rnd rsp1_valid", 64'(rsp1_valid), 64'(e_r1v));
      chk("rnd rsp1_rdata", 64'(rsp1_rdata), 64'(e_r1d));
`ifdef DMEM_ARB_STATS_EN
      chk("rnd grant0_count", 64'(grant0_count), 64'(e_c0));
      chk("rnd grant1_count", 64'(grant1_count), 64'(e_c1));
`endif
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
